// File: rtl/hier_node_fanin_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hier_fanin_pkg
//  Description : Shared defaults, types and helpers for the hierarchy fan-in
//                arbiter and its round-robin picker.
//  Contents    : N_CHILD_DEF / DATA_W_DEF / COUNT_W_DEF defaults,
//                out_state_e output-register state type,
//                src_w() child-index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package hier_fanin_pkg;

  localparam int N_CHILD_DEF = 5;
  localparam int DATA_W_DEF  = 8;
  localparam int COUNT_W_DEF = 16;

  // Occupancy of the single parent-facing output register.
  typedef enum logic [0:0] {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Bits needed to hold a child index 0..n-1, never less than one bit so
  // that a degenerate configuration still produces a legal vector width.
  // The loop stops at bit 30 to keep (1 << i) a positive int.
  function automatic int src_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage : hier_fanin_pkg
`default_nettype wire

// File: rtl/hier_node_fanin_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : hier_rr_pick
//  Description : Purely combinational round-robin picker. Searches req
//                starting one position after 'last', wrapping at N, and
//                returns the first requester found.
//  Ports       : req     [N]     - request vector
//                last    [SRC_W] - index granted most recently
//                en      [1]     - search enable; gnt is zero when low
//                gnt     [N]     - one-hot grant (or zero)
//                gnt_idx [SRC_W] - binary index of the granted requester
//                any     [1]     - a grant was issued
//  Revision    : 1.0 - initial release
// ============================================================================
module hier_rr_pick
  import hier_fanin_pkg::*;
#(
  parameter int N     = N_CHILD_DEF,
  parameter int SRC_W = src_w(N_CHILD_DEF)
) (
  input  logic [N-1:0]     req,
  input  logic [SRC_W-1:0] last,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [SRC_W-1:0] gnt_idx,
  output logic             any
);

  int               start_pos;
  int               probe;
  logic [SRC_W-1:0] probe_idx;

  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    any       = 1'b0;
    probe     = 0;
    probe_idx = '0;

    // Starting point is last+1 with an explicit wrap: N need not be a power
    // of two, so natural overflow of the index vector cannot be relied on.
    // An out-of-range 'last' restarts the search at 0.
    if (int'(last) >= N - 1) begin
      start_pos = 0;
    end else begin
      start_pos = int'(last) + 1;
    end

    for (int k = 0; k < N; k++) begin
      probe = start_pos + k;
      if (probe >= N) probe = probe - N;
      probe_idx = SRC_W'(probe);
      if (en && !any && req[probe_idx]) begin
        gnt[probe_idx] = 1'b1;
        gnt_idx        = probe_idx;
        any            = 1'b1;
      end
    end
  end

endmodule : hier_rr_pick
`default_nettype wire

// File: rtl/hier_node_fanin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hier_node_fanin_arbiter
//  Description : Merges N_CHILD upstream valid/ready channels into a single
//                registered parent-facing stream. Children are served in
//                round-robin order; each forwarded item is tagged with the
//                index of the child that supplied it. Sustains one item per
//                cycle when the parent is always ready.
//  Ports       : clk       [1]              - rising-edge clock
//                rst_n     [1]              - asynchronous active-low reset
//                in_valid  [N_CHILD]        - per-child valid
//                in_data   [N_CHILD*DATA_W] - child i at [i*DATA_W +: DATA_W]
//                in_ready  [N_CHILD]        - per-child ready, one-hot or zero
//                out_valid [1]              - parent-side valid
//                out_data  [DATA_W]         - registered payload
//                out_src   [SRC_W]          - child index of out_data
//                out_ready [1]              - parent-side ready
//                tx_count  [COUNT_W]        - parent handshakes, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
module hier_node_fanin_arbiter
  import hier_fanin_pkg::*;
#(
  parameter  int N_CHILD = N_CHILD_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int COUNT_W = COUNT_W_DEF,
  localparam int SRC_W   = src_w(N_CHILD)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CHILD-1:0]          in_valid,
  input  logic [N_CHILD*DATA_W-1:0]   in_data,
  output logic [N_CHILD-1:0]          in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready,
  output logic [COUNT_W-1:0]          tx_count
);

  // Pointer reset value: the search begins one past this, i.e. at child 0.
  localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(N_CHILD - 1);

  out_state_e         out_state_q, out_state_d;
  logic [DATA_W-1:0]  out_data_q,  out_data_d;
  logic [SRC_W-1:0]   out_src_q,   out_src_d;
  logic [SRC_W-1:0]   last_grant_q, last_grant_d;
  logic [COUNT_W-1:0] tx_count_q,  tx_count_d;

  logic               load;
  logic               parent_hs;
  logic [N_CHILD-1:0] pick_gnt;
  logic [SRC_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  win_data;

  // The output register can accept a new item when it is empty or is being
  // emptied this very cycle; this is what allows back-to-back transfers.
  assign load      = (out_state_q == OUT_EMPTY) || out_ready;
  assign parent_hs = (out_state_q == OUT_FULL) && out_ready;

  hier_rr_pick #(
    .N     (N_CHILD),
    .SRC_W (SRC_W)
  ) u_pick (
    .req     (in_valid),
    .last    (last_grant_q),
    .en      (load),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // The grant is derived from in_valid and local state only; the payload
  // never feeds back into the ready path.
  assign in_ready = pick_gnt;

  // One-hot payload mux driven by the grant vector.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_CHILD; i++) begin
      if (pick_gnt[i]) win_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    out_state_d  = out_state_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    tx_count_d   = tx_count_q;

    if (parent_hs) begin
      tx_count_d = tx_count_q + COUNT_W'(1);
    end

    // A grant always wins over draining: the register reloads and stays
    // full. Without a grant, a parent handshake empties it. With neither,
    // everything (including the pointer) holds.
    if (pick_any) begin
      out_state_d  = OUT_FULL;
      out_data_d   = win_data;
      out_src_d    = pick_idx;
      last_grant_d = pick_idx;
    end else if (parent_hs) begin
      out_state_d  = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_state_q  <= OUT_EMPTY;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= LAST_RST;
      tx_count_q   <= '0;
    end else begin
      out_state_q  <= out_state_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      tx_count_q   <= tx_count_d;
    end
  end

  assign out_valid = (out_state_q == OUT_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign tx_count  = tx_count_q;

endmodule : hier_node_fanin_arbiter
`default_nettype wire

// File: tb/tb_hier_node_fanin_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hier_node_fanin_arbiter
//  Description : Self-checking bench for hier_node_fanin_arbiter. A
//                reference model predicts grants and pushes expected items
//                into a scoreboard; a monitor pops them on parent handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hier_node_fanin_arbiter;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      in_valid;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_src;
  logic              out_ready;
  logic [CW-1:0]     tx_count;

  always #5 clk = ~clk;

  hier_node_fanin_arbiter #(
    .N_CHILD (N),
    .DATA_W  (DW),
    .COUNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .tx_count  (tx_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int data;
    int src;
  } item_t;

  item_t sb[$];
  int    m_last;
  bit    m_valid;
  int    m_data;
  int    m_src;
  int    m_cnt;

  // Predictor: at each falling edge checks the DUT state against the model,
  // then decides what the coming rising edge will do.
  always @(negedge clk) begin
    int   g;
    int   c;
    bit   ld;
    int   exp_rdy;
    if (!rst_n) begin
      m_last  = N - 1;
      m_valid = 1'b0;
      m_data  = 0;
      m_src   = 0;
      m_cnt   = 0;
      sb.delete();
    end else begin
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("tx_count", 64'(tx_count), 64'(m_cnt));
      if (m_valid) begin
        check("reg_data", 64'(out_data), 64'(m_data));
        check("reg_src", 64'(out_src), 64'(m_src));
      end
      ld = !m_valid || out_ready;
      g  = -1;
      if (ld) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (g < 0 && in_valid[c]) g = c;
        end
      end
      exp_rdy = (g >= 0) ? (1 << g) : 0;
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (m_valid && out_ready) m_cnt = (m_cnt + 1) % (1 << CW);
      if (g >= 0) begin
        m_data  = int'((in_data >> (g * DW)) & {{(N*DW-DW){1'b0}}, {DW{1'b1}}});
        m_src   = g;
        m_valid = 1'b1;
        m_last  = g;
        sb.push_back('{data: m_data, src: g});
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Monitor: every parent handshake must match the oldest expected item.
  always @(negedge clk) begin
    item_t it;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: handshake src=%0d data=0x%0h, expected none", out_src, out_data);
      end else begin
        it = sb.pop_front();
        check("sb_data", 64'(out_data), 64'(it.data));
        check("sb_src", 64'(out_src), 64'(it.src));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_data(input int ch, input int val);
    in_data[ch*DW +: DW] = DW'(val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt_before;
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_tx_count", 64'(tx_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Rotation: all children valid, parent always ready.
    for (int i = 0; i < N; i++) set_data(i, 'h10 + i);
    in_valid  = '1;
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("rot_src", 64'(out_src), 64'(j % N));
      check("rot_data", 64'(out_data), 64'('h10 + (j % N)));
      check("rot_valid", 64'(out_valid), 64'd1);
    end

    // Drain, then backpressure on a single child.
    in_valid = '0;
    repeat (2) tick();
    cnt_before = m_cnt;
    in_valid   = N'(1 << 3);
    set_data(3, 'hA5);
    out_ready  = 1'b0;
    tick();
    in_valid = '0;
    for (int j = 0; j < 4; j++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'hA5);
      check("bp_src", 64'(out_src), 64'd3);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_one_hs", 64'(tx_count), 64'((cnt_before + 1) % (1 << CW)));
    check("bp_drained", 64'(out_valid), 64'd0);
    tick();

    // Skip idle children: only 1 and 4 requesting, pointer left at 1.
    out_ready = 1'b1;
    in_valid  = N'(1 << 1);
    tick();
    in_valid = N'((1 << 1) | (1 << 4));
    for (int j = 0; j < 4; j++) begin
      tick();
      check("skip_src", 64'(out_src), 64'((j % 2 == 0) ? 4 : 1));
    end
    in_valid = '0;
    repeat (2) tick();

    // Randomized traffic with random backpressure and dropping valids.
    for (int j = 0; j < 400; j++) begin
      in_valid  = N'($urandom);
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reset in mid-stream while the output register is full.
    in_valid  = '1;
    out_ready = 1'b1;
    repeat (2) tick();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_data", 64'(out_data), 64'd0);
    check("mrst_out_src", 64'(out_src), 64'd0);
    check("mrst_tx_count", 64'(tx_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First post-reset grant goes to child 0; 17 handshakes wrap a 4-bit count.
    for (int i = 0; i < N; i++) set_data(i, 'h30 + i);
    tick();
    check("post_rst_src", 64'(out_src), 64'd0);
    check("post_rst_data", 64'(out_data), 64'h30);
    repeat (17) tick();
    out_ready = 1'b0;
    in_valid  = '0;
    check("wrap_count", 64'(tx_count), 64'd1);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_hier_node_fanin_arbiter
`default_nettype wire

// File: doc/hier_node_fanin_arbiter.md
Name: hier_node_fanin_arbiter

Overview:
Fan-in counterpart to the hierarchy fan-out nodes. A parent node fans out to five child instances; this block collects upstream traffic from those five children and merges it into one parent-facing stream. Each child drives a valid/ready channel. The block round-robin arbitrates the children, registers the winner, tags it with the child index and forwards it upward. It is instantiated once per hierarchy node and can be chained to build a reporting tree.

Parameters:
N_CHILD, 5, number of child channels (2..16)
DATA_W, 8, payload width per channel
COUNT_W, 16, width of the forwarded-transaction counter

Ports:
clk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  N_CHILD  per-child valid
in_data  in  N_CHILD*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W]
in_ready  out  N_CHILD  per-child ready, one-hot or zero
out_valid  out  1  parent-side valid
out_data  out  DATA_W  registered payload
out_src  out  SRC_W  index of the child that supplied out_data; SRC_W = clog2(N_CHILD)
out_ready  in  1  parent-side ready
tx_count  out  COUNT_W  number of completed parent-side handshakes

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (async assert, sync deassert by the system):
  - out_valid=0, out_data=0, out_src=0, tx_count=0.
  - Internal pointer last_grant=N_CHILD-1, so the first search starts at child 0.
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = !out_valid || out_ready. This is combinational and gives a pipeline-ready slot.
- Grant selection (combinational):
  - When load=1, pick the first asserted in_valid searching from last_grant+1 upward, wrapping mod N_CHILD.
  - in_ready = one-hot grant. When load=0 or no valid is asserted, in_ready=0.
  - in_ready never depends on in_data.
- On a child handshake (in_valid[i] && in_ready[i]):
  - Next edge: out_data<=in_data[i], out_src<=i, out_valid<=1, last_grant<=i.
  - Latency is one cycle from child handshake to out_valid.
- Parent handshake (out_valid && out_ready) with no simultaneous grant: out_valid<=0 next edge.
- Handshake plus a new grant in the same cycle: the register reloads and out_valid stays 1. This gives full throughput of 1 item/cycle.
- Hold rule: while out_valid && !out_ready, out_data and out_src must stay stable and in_ready must be all zero.
- last_grant updates only on a grant. Idle cycles do not move the pointer.
- Fairness: with all children continuously valid and out_ready=1, grants rotate 0,1,...,N_CHILD-1,0,...
- tx_count: +1 on each parent handshake; wraps from 2^COUNT_W-1 to 0 with no saturation.
- Children may drop in_valid without a handshake; this is tolerated and no grant is issued. The block must never accept from a child whose in_valid is 0.
- Reset mid-transfer: any held item is discarded, all outputs return to reset values immediately, and tx_count clears.
- Arithmetic: pointer increment wraps explicitly at N_CHILD. It must not rely on power-of-two overflow, because N_CHILD=5.

Decomposition:
- Package hier_fanin_pkg:
  - defaults N_CHILD_DEF=5, DATA_W_DEF=8, COUNT_W_DEF=16
  - function src_w(n) returning clog2(n) with a minimum of 1
- One sub-module hier_rr_pick: purely combinational round-robin picker.
  - Inputs: req[N], last[SRC_W], en.
  - Outputs: gnt[N] one-hot, gnt_idx, any.
- The top holds the output register, last_grant and tx_count.

Test Plan:
- Reset check: rst_n low mid-stream with out_valid=1 → all outputs 0 within the same cycle, and the first post-reset grant goes to child 0.
- Rotation: all 5 in_valid held high, out_ready=1, data = 0x10+i → out_src sequence 0,1,2,3,4,0, out_data 0x10..0x14, one item/cycle after 1-cycle latency.
- Backpressure: in_valid[3]=1 with data 0xA5, out_ready=0 for 4 cycles → out_valid=1, out_data=0xA5 and out_src=3 stable, in_ready=0 throughout; release → exactly one handshake, tx_count=1.
- Skip idle: only children 1 and 4 valid, last_grant=1 → next grant 4, then 1; children 2 and 3 are never granted.
- Wrap count: COUNT_W=4, 17 parent handshakes → tx_count reads 1.
- Simultaneous: out_valid=1, out_ready=1 and in_valid[2]=1 in the same cycle → out_valid stays 1, out_src=2 next cycle, no bubble.
